// File: rtl/sw_pattern_sequencer.sv
// Self-test sequencer: forwards switches when idle, otherwise steps through 16 nibble patterns and signs the LED response.
// Latency: 1 clock switch passthrough; a full run is 16*HOLD_CYCLES clocks from START to the DONE pulse.
// Backpressure: none; START is honoured only when idle and ABORT only while a run is applying patterns.
module sw_pattern_sequencer #(
    parameter int WIDTH       = 12,
    parameter int HOLD_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [3:0]       step,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        FIN
    } state_t;

    state_t           state, state_nxt;
    logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
    logic [3:0]       step_nxt;
    logic [WIDTH-1:0] sw_out_nxt, signature_nxt;
    logic             busy_nxt, done_nxt, aborted_nxt;
    logic [3:0]       step_inc;

    function automatic logic [WIDTH-1:0] pattern(input logic [3:0] n);
        return {(WIDTH/4){n}};
    endfunction

    assign step_inc = step + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            step      <= '0;
            sw_out    <= '0;
            signature <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            step      <= step_nxt;
            sw_out    <= sw_out_nxt;
            signature <= signature_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        step_nxt      = step;
        sw_out_nxt    = sw_out;
        signature_nxt = signature;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        aborted_nxt   = aborted;
        unique case (state)
            IDLE: begin
                sw_out_nxt = sw_in;
                if (start) begin
                    state_nxt     = APPLY;
                    step_nxt      = '0;
                    sw_out_nxt    = pattern(4'd0);
                    hold_cnt_nxt  = '0;
                    signature_nxt = '0;
                    aborted_nxt   = 1'b0;
                    busy_nxt      = 1'b1;
                end
            end
            APPLY: begin
                // Abort freezes step and signature at their partial values.
                if (abort) begin
                    state_nxt   = IDLE;
                    busy_nxt    = 1'b0;
                    aborted_nxt = 1'b1;
                    sw_out_nxt  = sw_in;
                end else if (hold_cnt == HOLD_LAST) begin
                    signature_nxt = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ led_in;
                    if (step == 4'd15) begin
                        state_nxt = FIN;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        step_nxt     = step_inc;
                        sw_out_nxt   = pattern(step_inc);
                        hold_cnt_nxt = '0;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sw_pattern_sequencer.sv
// Randomised bench for sw_pattern_sequencer: HOLD_CYCLES=10 and HOLD_CYCLES=1 instances against a plain-arithmetic signature model.
module tb_sw_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, start1, abort1, led_sel;
    logic [11:0] sw_in, led_key, led_const, led_in, led_in1;
    logic [11:0] sw_out, signature, sw_out1, signature1;
    logic [3:0]  step, step1;
    logic        busy, done, aborted, busy1, done1, aborted1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // The datapath under test: a XOR lookup of sw_out, or a constant.
    assign led_in  = led_sel ? led_const : (sw_out ^ led_key);
    assign led_in1 = sw_out1 ^ led_key;

    sw_pattern_sequencer #(.WIDTH(12), .HOLD_CYCLES(10)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sw_in(sw_in), .led_in(led_in), .sw_out(sw_out), .step(step),
        .signature(signature), .busy(busy), .done(done), .aborted(aborted)
    );

    sw_pattern_sequencer #(.WIDTH(12), .HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .sw_in(sw_in), .led_in(led_in1), .sw_out(sw_out1), .step(step1),
        .signature(signature1), .busy(busy1), .done(done1), .aborted(aborted1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pat(input int n);
        return 12'(n * 'h111);
    endfunction

    function automatic logic [11:0] fold(input logic [11:0] s, input logic [11:0] led);
        int v;
        v = int'(s);
        v = ((v * 2) % 4096) + (v / 2048);
        return 12'(v) ^ led;
    endfunction

    task automatic test_reset;
        #12;
        n_checks += 8;
        if (sw_out !== 12'h000)    begin n_fail++; $display("FAIL reset_sw_out got %h want 000", sw_out); end
        if (step !== 4'h0)         begin n_fail++; $display("FAIL reset_step got %h want 0", step); end
        if (signature !== 12'h000) begin n_fail++; $display("FAIL reset_signature got %h want 000", signature); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)         begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (aborted !== 1'b0)      begin n_fail++; $display("FAIL reset_aborted got %b want 0", aborted); end
        if (sw_out1 !== 12'h000)   begin n_fail++; $display("FAIL reset_sw_out1 got %h want 000", sw_out1); end
        if (busy1 !== 1'b0)        begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough;
        sw_in = 12'hA5C;
        tick();
        n_checks += 2;
        if (sw_out !== 12'hA5C) begin n_fail++; $display("FAIL passthru_a5c got %h want a5c", sw_out); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL passthru_busy got %b want 0", busy); end
        for (int i = 0; i < 6; i++) begin
            logic [11:0] v;
            v = 12'($urandom);
            sw_in = v;
            tick();
            n_checks++;
            if (sw_out !== v) begin n_fail++; $display("FAIL passthru_rand got %h want %h", sw_out, v); end
        end
    endtask

    // Full HOLD=10 run; optionally pokes START mid-run, which must be ignored.
    task automatic run10(input string tag, input bit use_const, input bit poke_start,
                         output logic [11:0] got_sig);
        logic [11:0] model, smp, hold_sw;
        int poke_at;
        model   = 12'h000;
        poke_at = int'($urandom_range(5, 150));
        got_sig = 12'hxxx;
        sw_in   = 12'($urandom);
        start   = 1'b1;
        abort   = 1'($urandom_range(0, 1));
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        for (int c = 0; c <= 160; c++) begin
            if (c > 0 && c % 10 == 0) begin
                smp   = use_const ? led_const : (pat(c / 10 - 1) ^ led_key);
                model = fold(model, smp);
            end
            n_checks += 5;
            if (signature !== model) begin n_fail++; $display("FAIL %s sig c=%0d got %h want %h", tag, c, signature, model); end
            if (c < 160) begin
                if (sw_out !== pat(c / 10)) begin n_fail++; $display("FAIL %s sw_out c=%0d got %h want %h", tag, c, sw_out, pat(c / 10)); end
                if (step !== 4'(c / 10))   begin n_fail++; $display("FAIL %s step c=%0d got %0d want %0d", tag, c, step, c / 10); end
                if (busy !== 1'b1)         begin n_fail++; $display("FAIL %s busy c=%0d got %b want 1", tag, c, busy); end
                if (done !== 1'b0)         begin n_fail++; $display("FAIL %s done c=%0d got %b want 0", tag, c, done); end
                if (poke_start && c == poke_at) start = 1'b1;
                sw_in = 12'($urandom);
                tick();
                start = 1'b0;
            end else begin
                got_sig = signature;
                if (sw_out !== pat(15)) begin n_fail++; $display("FAIL %s fin_sw_out got %h want fff", tag, sw_out); end
                if (step !== 4'd15)     begin n_fail++; $display("FAIL %s fin_step got %0d want 15", tag, step); end
                if (busy !== 1'b0)      begin n_fail++; $display("FAIL %s fin_busy got %b want 0", tag, busy); end
                if (done !== 1'b1)      begin n_fail++; $display("FAIL %s done_pulse got %b want 1", tag, done); end
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks += 3;
        if (done !== 1'b0)      begin n_fail++; $display("FAIL %s done_width got %b want 0", tag, done); end
        if (sw_out !== pat(15)) begin n_fail++; $display("FAIL %s fin_hold got %h want fff", tag, sw_out); end
        if (aborted !== 1'b0)   begin n_fail++; $display("FAIL %s abort_in_fin got %b want 0", tag, aborted); end
        hold_sw = 12'($urandom);
        sw_in   = hold_sw;
        tick();
        n_checks += 2;
        if (sw_out !== hold_sw) begin n_fail++; $display("FAIL %s resume got %h want %h", tag, sw_out, hold_sw); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL %s idle_busy got %b want 0", tag, busy); end
    endtask

    task automatic test_loopback;
        logic [11:0] s;
        led_sel = 1'b0;
        led_key = 12'h000;
        run10("loopback", 1'b0, 1'b0, s);
    endtask

    task automatic test_random_lut;
        logic [11:0] s;
        for (int i = 0; i < 3; i++) begin
            led_sel = 1'b0;
            led_key = 12'($urandom);
            run10("lut_start_poke", 1'b0, 1'b1, s);
        end
    endtask

    task automatic test_signature_const;
        logic [11:0] s;
        led_sel   = 1'b1;
        led_const = 12'h001;
        run10("const001", 1'b1, 1'b0, s);
        n_checks++;
        if (s !== 12'hFF0) begin n_fail++; $display("FAIL const001_sig got %h want ff0", s); end
        led_const = 12'h000;
        run10("const000", 1'b1, 1'b0, s);
        n_checks++;
        if (s !== 12'h000) begin n_fail++; $display("FAIL const000_sig got %h want 000", s); end
        led_sel = 1'b0;
    endtask

    task automatic test_abort;
        logic [11:0] model, v;
        int  r;
        bit  seen_done;
        led_sel = 1'b0;
        led_key = 12'($urandom);
        model   = 12'h000;
        r       = int'($urandom_range(0, 9));
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int c = 0; c < 50 + r; c++) begin
            sw_in = 12'($urandom);
            tick();
            if ((c + 1) % 10 == 0) model = fold(model, pat((c + 1) / 10 - 1) ^ led_key);
        end
        n_checks++;
        if (step !== 4'd5) begin n_fail++; $display("FAIL abort_pre_step got %0d want 5", step); end
        v     = 12'($urandom);
        sw_in = v;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks += 6;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        if (aborted !== 1'b1)    begin n_fail++; $display("FAIL abort_flag got %b want 1", aborted); end
        if (sw_out !== v)        begin n_fail++; $display("FAIL abort_sw_out got %h want %h", sw_out, v); end
        if (step !== 4'd5)       begin n_fail++; $display("FAIL abort_step got %0d want 5", step); end
        if (done !== 1'b0)       begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        if (signature !== model) begin n_fail++; $display("FAIL abort_sig got %h want %h", signature, model); end
        seen_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            sw_in = 12'($urandom);
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        n_checks += 5;
        if (seen_done)           begin n_fail++; $display("FAIL abort_no_done got 1 want 0"); end
        if (step !== 4'd5)       begin n_fail++; $display("FAIL abort_step_hold got %0d want 5", step); end
        if (aborted !== 1'b1)    begin n_fail++; $display("FAIL abort_sticky got %b want 1", aborted); end
        if (signature !== model) begin n_fail++; $display("FAIL abort_sig_hold got %h want %h", signature, model); end
        if (sw_out !== sw_in)    begin n_fail++; $display("FAIL abort_passthru got %h want %h", sw_out, sw_in); end
    endtask

    task automatic test_midrun_reset;
        int  waited;
        bit  seen_done;
        logic [11:0] v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        waited = 0;
        while (step !== 4'd7 && waited < 200) begin
            tick();
            waited++;
        end
        n_checks++;
        if (step !== 4'd7) begin n_fail++; $display("FAIL rst_wait_step7 got %0d want 7", step); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 6;
        if (sw_out !== 12'h000)    begin n_fail++; $display("FAIL rst_async_sw_out got %h want 000", sw_out); end
        if (step !== 4'h0)         begin n_fail++; $display("FAIL rst_async_step got %h want 0", step); end
        if (signature !== 12'h000) begin n_fail++; $display("FAIL rst_async_sig got %h want 000", signature); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_async_busy got %b want 0", busy); end
        if (done !== 1'b0)         begin n_fail++; $display("FAIL rst_async_done got %b want 0", done); end
        if (aborted !== 1'b0)      begin n_fail++; $display("FAIL rst_async_aborted got %b want 0", aborted); end
        seen_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        v     = 12'($urandom);
        sw_in = v;
        tick();
        n_checks += 3;
        if (seen_done)     begin n_fail++; $display("FAIL rst_no_done got 1 want 0"); end
        if (sw_out !== v)  begin n_fail++; $display("FAIL rst_idle_passthru got %h want %h", sw_out, v); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got %b want 0", busy); end
    endtask

    // Checks a HOLD=1 run starting just after its accepting START edge.
    task automatic check_run1(input string tag);
        logic [11:0] model;
        model = 12'h000;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) model = fold(model, pat(c - 1) ^ led_key);
            n_checks += 4;
            if (signature1 !== model) begin n_fail++; $display("FAIL %s sig c=%0d got %h want %h", tag, c, signature1, model); end
            if (c < 16) begin
                if (sw_out1 !== pat(c)) begin n_fail++; $display("FAIL %s sw_out c=%0d got %h want %h", tag, c, sw_out1, pat(c)); end
                if (step1 !== 4'(c))    begin n_fail++; $display("FAIL %s step c=%0d got %0d want %0d", tag, c, step1, c); end
                if (done1 !== 1'b0)     begin n_fail++; $display("FAIL %s done c=%0d got %b want 0", tag, c, done1); end
                sw_in = 12'($urandom);
                tick();
            end else begin
                if (done1 !== 1'b1) begin n_fail++; $display("FAIL %s done_pulse got %b want 1", tag, done1); end
                if (busy1 !== 1'b0) begin n_fail++; $display("FAIL %s fin_busy got %b want 0", tag, busy1); end
                if (step1 !== 4'd15) begin n_fail++; $display("FAIL %s fin_step got %0d want 15", tag, step1); end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_hold1;
        led_key = 12'($urandom);
        start1  = 1'b1;
        tick();
        start1  = 1'b0;
        check_run1("hold1_first");
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        n_checks += 2;
        if (aborted1 !== 1'b1) begin n_fail++; $display("FAIL hold1_abort got %b want 1", aborted1); end
        if (step1 !== 4'd2)    begin n_fail++; $display("FAIL hold1_abort_step got %0d want 2", step1); end
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_checks += 3;
        if (aborted1 !== 1'b0)      begin n_fail++; $display("FAIL hold1_restart_aborted got %b want 0", aborted1); end
        if (signature1 !== 12'h000) begin n_fail++; $display("FAIL hold1_restart_sig got %h want 000", signature1); end
        if (busy1 !== 1'b1)         begin n_fail++; $display("FAIL hold1_restart_busy got %b want 1", busy1); end
        check_run1("hold1_restart");
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        start1    = 1'b0;
        abort1    = 1'b0;
        led_sel   = 1'b0;
        led_key   = 12'h000;
        led_const = 12'h000;
        sw_in     = 12'h000;
        test_reset();
        test_passthrough();
        test_loopback();
        test_random_lut();
        test_signature_const();
        test_abort();
        test_midrun_reset();
        test_hold1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
